// File: rtl/jtag_loopback_selftest.sv
// rtl/jtag_loopback_selftest.sv - clocked loopback pattern engine for the buffer CPLD self-test
module jtag_loopback_selftest #(
    parameter int CHANNELS  = 8,
    parameter int SETTLE    = 4,
    parameter int BLINK_BIT = 22
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                nTEST_REQ,
    input  logic [CHANNELS-1:0] SNS,
    output logic [CHANNELS-1:0] DRV,
    output logic                DRV_OE,
    output logic                BUSY,
    output logic                DONE,
    output logic                PASS,
    output logic [CHANNELS-1:0] FAIL_MASK,
    output logic                LED
);

    localparam int NSTEPS = 2 * CHANNELS + 2;
    localparam int SW     = $clog2(NSTEPS);
    localparam int CW     = $clog2(SETTLE);
    localparam logic [SW-1:0] LAST_STEP = SW'(NSTEPS - 1);
    localparam logic [CW-1:0] CNT_INIT  = CW'(SETTLE - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CHECK, ST_REPORT} state_t;

    state_t              state, state_nxt;
    logic                req_m, req_s, req_d;
    logic [CHANNELS-1:0] sns_m, sns_s;
    logic [SW-1:0]       step, step_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [CHANNELS-1:0] drv_nxt, mask_nxt;
    logic                oe_nxt, busy_nxt, done_nxt, pass_nxt;
    logic [BLINK_BIT:0]  blink;
    logic                start;

    // Zeros, ones, walking one, then walking zero.
    function automatic logic [CHANNELS-1:0] pattern(input logic [SW-1:0] s);
        logic [CHANNELS-1:0] p;
        int idx;
        idx = int'(s);
        for (int i = 0; i < CHANNELS; i++) begin
            if (idx == 0)
                p[i] = 1'b0;
            else if (idx == 1)
                p[i] = 1'b1;
            else if (idx < CHANNELS + 2)
                p[i] = (i == idx - 2);
            else
                p[i] = (i != idx - CHANNELS - 2);
        end
        return p;
    endfunction

    // Synchronisers reset to "not requested" so releasing reset never looks like a start.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            req_m <= 1'b0;
            req_s <= 1'b0;
            req_d <= 1'b0;
            sns_m <= '0;
            sns_s <= '0;
            blink <= '0;
        end else begin
            req_m <= ~nTEST_REQ;
            req_s <= req_m;
            req_d <= req_s;
            sns_m <= SNS;
            sns_s <= sns_m;
            blink <= blink + 1'b1;
        end
    end

    assign start = req_s & ~req_d;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= ST_IDLE;
            step      <= '0;
            cnt       <= '0;
            DRV       <= '0;
            DRV_OE    <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
            FAIL_MASK <= '0;
        end else begin
            state     <= state_nxt;
            step      <= step_nxt;
            cnt       <= cnt_nxt;
            DRV       <= drv_nxt;
            DRV_OE    <= oe_nxt;
            BUSY      <= busy_nxt;
            DONE      <= done_nxt;
            PASS      <= pass_nxt;
            FAIL_MASK <= mask_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        cnt_nxt   = cnt;
        drv_nxt   = DRV;
        oe_nxt    = DRV_OE;
        busy_nxt  = BUSY;
        done_nxt  = DONE;
        pass_nxt  = PASS;
        mask_nxt  = FAIL_MASK;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    step_nxt  = '0;
                    drv_nxt   = pattern('0);
                    oe_nxt    = 1'b1;
                    busy_nxt  = 1'b1;
                    done_nxt  = 1'b0;
                    pass_nxt  = 1'b0;
                    mask_nxt  = '0;
                    cnt_nxt   = CNT_INIT;
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE, ST_CHECK: begin
                if (!req_s) begin
                    // Abort keeps the partial mask so the bench can see how far it got.
                    drv_nxt   = '0;
                    oe_nxt    = 1'b0;
                    busy_nxt  = 1'b0;
                    state_nxt = ST_IDLE;
                end else if (state == ST_SETTLE) begin
                    if (cnt == '0)
                        state_nxt = ST_CHECK;
                    else
                        cnt_nxt = cnt - 1'b1;
                end else begin
                    mask_nxt = FAIL_MASK | (sns_s ^ DRV);
                    if (step == LAST_STEP) begin
                        state_nxt = ST_REPORT;
                    end else begin
                        step_nxt  = step + 1'b1;
                        drv_nxt   = pattern(step + 1'b1);
                        cnt_nxt   = CNT_INIT;
                        state_nxt = ST_SETTLE;
                    end
                end
            end
            ST_REPORT: begin
                drv_nxt   = '0;
                oe_nxt    = 1'b0;
                busy_nxt  = 1'b0;
                done_nxt  = 1'b1;
                pass_nxt  = (FAIL_MASK == '0);
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign LED = BUSY | (DONE & (PASS | blink[BLINK_BIT]));

endmodule

// File: tb/tb_jtag_loopback_selftest.sv
// tb/tb_jtag_loopback_selftest.sv - self-checking bench for jtag_loopback_selftest
module tb_jtag_loopback_selftest;

    localparam int CH  = 4;
    localparam int ST  = 3;
    localparam int BB  = 3;
    localparam int NST = 2 * CH + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ntest_req = 1'b1;
    logic [CH-1:0] sns, drv, fail_mask;
    logic          drv_oe, busy, done, pass, led;

    logic [CH-1:0] sa0 = '0;
    logic [CH-1:0] sa1 = '0;
    logic          short_en = 1'b0;
    int            sh_a = 0;
    int            sh_b = 1;

    int            checks = 0;
    int            failures = 0;
    int unsigned   cyc;

    jtag_loopback_selftest #(.CHANNELS(CH), .SETTLE(ST), .BLINK_BIT(BB)) dut (
        .CLK(clk), .nRST(rst_n), .nTEST_REQ(ntest_req), .SNS(sns),
        .DRV(drv), .DRV_OE(drv_oe), .BUSY(busy), .DONE(done), .PASS(pass),
        .FAIL_MASK(fail_mask), .LED(led)
    );

    always #5 clk = ~clk;

    // Cycles since reset release: the blink counter's expected value.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [CH-1:0] pat(input int s);
        if (s == 0) return '0;
        if (s == 1) return '1;
        if (s < CH + 2) return CH'(1 << (s - 2));
        return ~CH'(1 << (s - CH - 2));
    endfunction

    function automatic logic [CH-1:0] sense(input logic [CH-1:0] p, input logic [CH-1:0] a0,
                                            input logic [CH-1:0] a1, input logic en,
                                            input int a, input int b);
        logic [CH-1:0] s;
        logic v;
        s = p;
        if (en) begin
            v = p[a] | p[b];
            s[a] = v;
            s[b] = v;
        end
        return (s & ~a0) | a1;
    endfunction

    assign sns = sense(drv, sa0, sa1, short_en, sh_a, sh_b);

    function automatic logic [CH-1:0] exp_mask(input int n);
        logic [CH-1:0] m;
        m = '0;
        for (int s = 0; s < n; s++)
            m |= sense(pat(s), sa0, sa1, short_en, sh_a, sh_b) ^ pat(s);
        return m;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_start();
        int lat;
        @(negedge clk);
        ntest_req = 1'b0;
        lat = 0;
        while (!drv_oe && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check_val("start_lat", lat, 3);
        check_val("busy_on", busy, 1);
        check_val("led_busy", led, 1);
    endtask

    task automatic run_full(input logic [CH-1:0] exp);
        int m;
        do_start();
        m = 0;
        while (!done && m < 200) begin
            if (m % (ST + 1) == 0 && m / (ST + 1) < NST)
                check_val($sformatf("drv_step%0d", m / (ST + 1)), drv, pat(m / (ST + 1)));
            @(negedge clk);
            m++;
        end
        check_val("done_lat", m, NST * (ST + 1) + 1);
        check_val("pass", pass, (exp == '0));
        check_val("fail_mask", fail_mask, exp);
        check_val("oe_off", drv_oe, 0);
        check_val("busy_off", busy, 0);
        check_val("drv_off", drv, 0);
        ntest_req = 1'b1;
        repeat (4) @(negedge clk);
        check_val("done_held", done, 1);
        for (int i = 0; i < 16; i++) begin
            check_val("led_done", led, (exp == '0) ? 1 : cyc[BB]);
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check_val("rst_drv", drv, 0);
        check_val("rst_oe", drv_oe, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_pass", pass, 0);
        check_val("rst_mask", fail_mask, 0);
        check_val("rst_led", led, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_val("idle_oe", drv_oe, 0);

        run_full(4'b0000);

        sa0 = 4'b0100;
        run_full(4'b0100);
        sa0 = '0;

        short_en = 1'b1; sh_a = 0; sh_b = 1;
        run_full(4'b0011);
        short_en = 1'b0;

        for (int t = 0; t < 6; t++) begin
            sa0 = ($urandom_range(0, 2) == 0) ? CH'($urandom) : '0;
            sa1 = ($urandom_range(0, 2) == 0) ? CH'($urandom) & ~sa0 : '0;
            short_en = $urandom_range(0, 1);
            sh_a = $urandom_range(0, CH - 1);
            sh_b = (sh_a + $urandom_range(1, CH - 1)) % CH;
            run_full(exp_mask(NST));
        end
        sa0 = '0; sa1 = '0; short_en = 1'b0;

        // Abort during step 5, with channel 0 stuck high so earlier steps leave bits.
        sa1 = 4'b0001;
        do_start();
        repeat (21) @(negedge clk);
        ntest_req = 1'b1;
        n = 0;
        while (drv_oe && n < 6) begin
            @(negedge clk);
            n++;
        end
        check_val("abort_lat", n, 3);
        check_val("abort_busy", busy, 0);
        check_val("abort_done", done, 0);
        check_val("abort_pass", pass, 0);
        check_val("abort_mask", fail_mask, exp_mask(5));
        run_full(exp_mask(NST));
        sa1 = '0;

        // Glitch the jumper between edges, then reset mid-step.
        do_start();
        repeat (10) @(negedge clk);
        #1 ntest_req = 1'b1;
        #2 ntest_req = 1'b0;
        repeat (8) @(negedge clk);
        check_val("glitch_busy", busy, 1);
        check_val("glitch_oe", drv_oe, 1);
        check_val("glitch_drv", drv, pat(4));
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_oe", drv_oe, 0);
        check_val("arst_drv", drv, 0);
        check_val("arst_busy", busy, 0);
        check_val("arst_done", done, 0);
        check_val("arst_pass", pass, 0);
        check_val("arst_mask", fail_mask, 0);
        check_val("arst_led", led, 0);
        ntest_req = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_val("post_rst_oe", drv_oe, 0);
        check_val("post_rst_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
